// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encoding and sizing helper for the universal shift register.
package univ_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Counter must be able to hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/univ_shift_reg_shift_cell.sv
// One storage bit of the shift register: synchronous reset value plus a
// 4:1 next-state mux (hold / upper neighbour / lower neighbour / load data).
module shift_cell
    import univ_shift_reg_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_mode,
    input  logic       i_from_hi,
    input  logic       i_from_lo,
    input  logic       i_d,
    output logic       o_q
);

    logic r_q;
    logic w_next;

    always_comb begin
        w_next = r_q;
        case (i_mode)
            MODE_SHR:  w_next = i_from_hi;
            MODE_SHL:  w_next = i_from_lo;
            MODE_LOAD: w_next = i_d;
            default:   w_next = r_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RST_BIT;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with gate, shift counter and Done flag.
// Optional rotate mode (port Rot) is enabled by defining UNIV_SHIFT_REG_ROTATE_EN.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               G,
    input  logic [1:0]                         S,
    input  logic [WIDTH-1:0]                   D,
    input  logic                               SinR,
    input  logic                               SinL,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic                               Rot,
`endif
    output logic [WIDTH-1:0]                   Q,
    output logic [WIDTH-1:0]                   Q1,
    output logic                               SoutR,
    output logic                               SoutL,
    output logic [cnt_width(WIDTH)-1:0]        CNT,
    output logic                               Done
);

    localparam int             CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] w_q;
    logic [1:0]       w_mode;
    logic             w_ser_hi;
    logic             w_ser_lo;
    logic [CW-1:0]    r_cnt;

    // A closed gate collapses every mode to hold before it reaches the cells.
    assign w_mode = G ? S : MODE_HOLD;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    assign w_ser_hi = Rot ? w_q[0]       : SinR;
    assign w_ser_lo = Rot ? w_q[WIDTH-1] : SinL;
`else
    assign w_ser_hi = SinR;
    assign w_ser_lo = SinL;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic w_hi;
        logic w_lo;

        if (i == WIDTH - 1) begin : g_top
            assign w_hi = w_ser_hi;
        end else begin : g_mid_hi
            assign w_hi = w_q[i+1];
        end

        if (i == 0) begin : g_bot
            assign w_lo = w_ser_lo;
        end else begin : g_mid_lo
            assign w_lo = w_q[i-1];
        end

        shift_cell #(
            .RST_BIT (RESET_VAL[i])
        ) u_cell (
            .i_clk     (Clk),
            .i_rst     (Reset),
            .i_mode    (w_mode),
            .i_from_hi (w_hi),
            .i_from_lo (w_lo),
            .i_d       (D[i]),
            .o_q       (w_q[i])
        );
    end

    // Saturating count of shifts since the last load; never wraps.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt <= '0;
        end else begin
            case (w_mode)
                MODE_LOAD: r_cnt <= '0;
                MODE_SHR,
                MODE_SHL: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign Q     = w_q;
    assign Q1    = ~w_q;
    assign SoutR = w_q[0];
    assign SoutL = w_q[WIDTH-1];
    assign CNT   = r_cnt;
    assign Done  = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8), with a second
// instance using RESET_VAL=8'hC3 to check the reset value path.
module tb_univ_shift_reg;

    logic       Clk;
    logic       Reset;
    logic       G;
    logic [1:0] S;
    logic [7:0] D;
    logic       SinR;
    logic       SinL;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic       Rot;
`endif

    logic [7:0] Q, Q1, Q_b, Q1_b;
    logic       SoutR, SoutL, SoutR_b, SoutL_b;
    logic [3:0] CNT, CNT_b;
    logic       Done, Done_b;

    int checks;
    int errors;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .G     (G),
        .S     (S),
        .D     (D),
        .SinR  (SinR),
        .SinL  (SinL),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .Rot   (Rot),
`endif
        .Q     (Q),
        .Q1    (Q1),
        .SoutR (SoutR),
        .SoutL (SoutL),
        .CNT   (CNT),
        .Done  (Done)
    );

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hC3)) dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .G     (G),
        .S     (S),
        .D     (D),
        .SinR  (SinR),
        .SinL  (SinL),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .Rot   (Rot),
`endif
        .Q     (Q_b),
        .Q1    (Q1_b),
        .SoutR (SoutR_b),
        .SoutL (SoutL_b),
        .CNT   (CNT_b),
        .Done  (Done_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] val);
        Reset = 1'b0; G = 1'b1; S = 2'b11; D = val;
        tick();
    endtask

    task automatic test_reset;
        Reset = 1'b1; G = 1'b1; S = 2'b11; D = 8'hFF; SinR = 1'b0; SinL = 1'b0;
        tick();
        Reset = 1'b0; S = 2'b00;
        checks++;
        if (Q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want %h", Q, 8'h00); end
        checks++;
        if (Q1 !== 8'hFF) begin errors++; $display("FAIL reset_q1 got %h want %h", Q1, 8'hFF); end
        checks++;
        if (CNT !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", CNT); end
        checks++;
        if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
        checks++;
        if (SoutR !== 1'b0 || SoutL !== 1'b0) begin
            errors++; $display("FAIL reset_sout got %b%b want 00", SoutL, SoutR);
        end
        checks++;
        if (Q_b !== 8'hC3) begin errors++; $display("FAIL reset_q_c3 got %h want %h", Q_b, 8'hC3); end
    endtask

    task automatic test_shift_right;
        logic [7:0] exp_sout;
        logic [7:0] exp_q [8];
        exp_sout = 8'b1010_0101;
        exp_q = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
        do_load(8'hA5);
        checks++;
        if (Q !== 8'hA5 || CNT !== 4'd0) begin
            errors++; $display("FAIL shr_load got q=%h cnt=%0d want q=a5 cnt=0", Q, CNT);
        end
        S = 2'b01; SinR = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (SoutR !== exp_sout[i]) begin
                errors++; $display("FAIL shr_sout[%0d] got %b want %b", i, SoutR, exp_sout[i]);
            end
            tick();
            checks++;
            if (Q !== exp_q[i] || CNT !== 4'(i + 1) || Done !== (i == 7)) begin
                errors++;
                $display("FAIL shr_step[%0d] got q=%h cnt=%0d done=%b want q=%h cnt=%0d done=%b",
                         i, Q, CNT, Done, exp_q[i], i + 1, (i == 7));
            end
        end
    endtask

    task automatic test_gate_hold;
        logic [1:0] modes [3];
        modes = '{2'b01, 2'b10, 2'b11};
        do_load(8'h81);
        G = 1'b0; D = 8'h3C; SinR = 1'b1; SinL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            S = modes[i % 3];
            tick();
            checks++;
            if (Q !== 8'h81 || CNT !== 4'd0) begin
                errors++; $display("FAIL gate_hold[%0d] got q=%h cnt=%0d want q=81 cnt=0", i, Q, CNT);
            end
        end
        G = 1'b1; SinR = 1'b0; SinL = 1'b0;
    endtask

    task automatic test_shift_left_sat;
        logic [7:0] exp_q [3];
        logic [3:0] exp_cnt;
        exp_q = '{8'h03, 8'h07, 8'h0F};
        do_load(8'h01);
        S = 2'b10; SinL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Q !== exp_q[i] || CNT !== 4'(i + 1)) begin
                errors++; $display("FAIL shl_step[%0d] got q=%h cnt=%0d want q=%h cnt=%0d",
                                   i, Q, CNT, exp_q[i], i + 1);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_cnt = (i + 4 > 8) ? 4'd8 : 4'(i + 4);
            checks++;
            if (CNT !== exp_cnt || Done !== (exp_cnt == 4'd8)) begin
                errors++; $display("FAIL shl_sat[%0d] got cnt=%0d done=%b want cnt=%0d done=%b",
                                   i, CNT, Done, exp_cnt, (exp_cnt == 4'd8));
            end
        end
        checks++;
        if (Q !== 8'hFF) begin errors++; $display("FAIL shl_fill got %h want ff", Q); end
        SinL = 1'b0;
        do_load(8'h55);
        checks++;
        if (Q !== 8'h55 || CNT !== 4'd0 || Done !== 1'b0) begin
            errors++; $display("FAIL load_after_done got q=%h cnt=%0d done=%b want q=55 cnt=0 done=0",
                               Q, CNT, Done);
        end
        S = 2'b00;
    endtask

    task automatic test_reset_mid;
        do_load(8'h3C);
        S = 2'b01; SinR = 1'b0;
        repeat (4) tick();
        checks++;
        if (Q !== 8'h03 || CNT !== 4'd4) begin
            errors++; $display("FAIL mid_pre got q=%h cnt=%0d want q=03 cnt=4", Q, CNT);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0; S = 2'b00;
        checks++;
        if (Q !== 8'h00 || CNT !== 4'd0 || Done !== 1'b0) begin
            errors++; $display("FAIL mid_reset got q=%h cnt=%0d done=%b want q=00 cnt=0 done=0",
                               Q, CNT, Done);
        end
        checks++;
        if (Q_b !== 8'hC3 || Q1_b !== 8'h3C || CNT_b !== 4'd0) begin
            errors++; $display("FAIL mid_reset_c3 got q=%h q1=%h cnt=%0d want q=c3 q1=3c cnt=0",
                               Q_b, Q1_b, CNT_b);
        end
        checks++;
        if (SoutR_b !== 1'b1 || SoutL_b !== 1'b1 || Done_b !== 1'b0) begin
            errors++; $display("FAIL mid_reset_c3_sout got l=%b r=%b done=%b want 1 1 0",
                               SoutL_b, SoutR_b, Done_b);
        end
    endtask

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    task automatic test_rotate;
        Rot = 1'b0;
        do_load(8'h81);
        Rot = 1'b1; SinR = 1'b0; SinL = 1'b0;
        S = 2'b01;
        tick();
        checks++;
        if (Q !== 8'hC0 || CNT !== 4'd1) begin
            errors++; $display("FAIL rot_r got q=%h cnt=%0d want q=c0 cnt=1", Q, CNT);
        end
        S = 2'b10;
        tick();
        checks++;
        if (Q !== 8'h81) begin errors++; $display("FAIL rot_l1 got %h want 81", Q); end
        tick();
        checks++;
        if (Q !== 8'h03 || CNT !== 4'd3) begin
            errors++; $display("FAIL rot_l2 got q=%h cnt=%0d want q=03 cnt=3", Q, CNT);
        end
        S = 2'b11; D = 8'h5A;
        tick();
        checks++;
        if (Q !== 8'h5A || CNT !== 4'd0) begin
            errors++; $display("FAIL rot_load got q=%h cnt=%0d want q=5a cnt=0", Q, CNT);
        end
        Rot = 1'b0; S = 2'b00;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b1; G = 1'b1; S = 2'b11; D = 8'hFF; SinR = 1'b0; SinL = 1'b0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        Rot = 1'b0;
`endif
        test_reset();
        test_shift_right();
        test_gate_hold();
        test_shift_left_sat();
        test_reset_mid();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        test_rotate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised N-bit universal shift register with four modes: hold, shift right, shift left and parallel load.
- A gate input, G, freezes the register, keeping the gated-storage behaviour of the lab's D latch in clocked, edge-triggered form.
- A shift counter and a Done flag report when every bit of a parallel-loaded word has been shifted out.
- Serves as the storage and serialiser element for the sequential-circuit labs.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q on reset.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- G  input  1  gate/enable; 0 forces hold regardless of S.
- S  input  2  mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- D  input  WIDTH  parallel load data.
- SinR  input  1  serial in, enters Q[WIDTH-1] on shift right.
- SinL  input  1  serial in, enters Q[0] on shift left.
- Q  output  WIDTH  register contents.
- Q1  output  WIDTH  bitwise complement of Q, combinational.
- SoutR  output  1  equals Q[0].
- SoutL  output  1  equals Q[WIDTH-1].
- CNT  output  $clog2(WIDTH+1)  shifts since last load, saturating.
- Done  output  1  high when CNT == WIDTH.

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled only on the rising edge of Clk.
- Reset has priority over all inputs. On a Reset edge: Q<=RESET_VAL, CNT<=0. Therefore Done=0 and Q1=~RESET_VAL.
- All state updates happen on the rising edge of Clk. Outputs change one cycle after the inputs are sampled; there is no combinational path from S, G or D to Q.
- G=0: Q and CNT hold for every value of S.
- G=1, S=00: hold; CNT unchanged.
- G=1, S=01: Q<={SinR, Q[WIDTH-1:1]}; CNT<=min(CNT+1, WIDTH).
- G=1, S=10: Q<={Q[WIDTH-2:0], SinL}; CNT<=min(CNT+1, WIDTH).
- G=1, S=11: Q<=D; CNT<=0.
- CNT saturates at WIDTH and never wraps. Done stays high while shifting continues after saturation, until the next load or reset.
- A load in the same cycle that Done is high clears CNT and Done on that edge.
- Reset asserted mid-shift-sequence abandons the sequence. No partial state is retained.
- Mixing shift directions is legal; each shift counts once.
- Q1, SoutR, SoutL and Done are pure functions of the registered state.

Optional Feature:
- Macro: UNIV_SHIFT_REG_ROTATE_EN.
- When defined, add input port Rot (1 bit). With Rot=1 in the shift modes:
  - Shift right rotates: Q<={Q[0], Q[WIDTH-1:1]}.
  - Shift left rotates: Q<={Q[WIDTH-2:0], Q[WIDTH-1]}.
  - SinR and SinL are ignored. CNT behaviour is unchanged.
- Rot has no effect in hold or load modes.
- When not defined, port Rot is absent and behaviour equals Rot=0.

Decomposition:
- Shared package `univ_shift_reg_pkg`:
  - Mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - Localparam helper for the CNT width, $clog2(WIDTH+1).
- One natural sub-module, `shift_cell`: a single flip-flop with synchronous reset value and a 4:1 next-state mux (hold / left neighbour / right neighbour / D). Instantiate it WIDTH times in a generate loop.
- The counter and Done logic stay in the top level.

Test Plan (WIDTH=8):
- Reset=1 for one edge with G=1, S=11, D=8'hFF -> Q=8'h00, Q1=8'hFF, CNT=0, Done=0. Reset wins over load.
- G=1, S=11, D=8'hA5, then S=01 with SinR=0 for 8 cycles -> SoutR sequence 1,0,1,0,0,1,0,1. Q=8'h00 after the 8th edge; CNT=8 and Done=1 after the 8th edge.
- Load 8'h81, then G=0 with S cycling 01/10/11 and D=8'h3C for 5 cycles -> Q stays 8'h81, CNT stays 0.
- Load 8'h01, then S=10 with SinL=1 for 3 cycles -> Q=8'h0F, CNT=3. Continue 10 more left shifts -> CNT saturates at 8 and Done holds 1. Then load 8'h55 -> CNT=0, Done=0 on the same edge.
- After 4 shifts from a load, assert Reset for one edge -> Q=RESET_VAL, CNT=0. With RESET_VAL=8'hC3, check Q1=8'h3C.
- With UNIV_SHIFT_REG_ROTATE_EN defined: load 8'h81, Rot=1, S=01 once -> Q=8'hC0. Then S=10 twice -> Q=8'h03. Each step ignores SinR/SinL (held at 0); CNT=3 at the end.
